self_test_sequencer: RTL and testbench

- Word-rate controller between eight_to_thirty_two, self_test and thirty_two_to_eight.
- Frames the deserialized 32-bit stream into packets (header + N payload words) and loads the payload into self_test.
- Starts the sort, waits for sort_finish with a timeout, then drains the results to the serializer path behind a status header.
- When f_layer=0 the block forwards words unmodified for the next layer.

---
 rtl/self_test_sequencer.sv | 160 ++++++++++++++++
 tb/tb_self_test_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/self_test_sequencer.sv
// self_test_sequencer: word-rate controller sitting between the 8->32
// deserializer, the self_test sorter and the 32->8 serializer. In first-layer
// mode it frames packets (header + N payload words), loads the payload into
// self_test, starts the sort, waits with a timeout, then drains the results
// behind a status header. In forward mode it passes words straight through.

module self_test_sequencer #(
  parameter int         MAX_WORDS = 16,
  parameter logic [7:0] SYNC      = 8'hA5,
  parameter int         TIMEOUT   = 1024
) (
  input  logic        div_8_clk,
  input  logic        rst,
  input  logic        f_layer,
  input  logic [31:0] word_in,
  input  logic        sort_finish,
  input  logic [31:0] st_data_in,
  output logic        st_load,
  output logic        st_start,
  output logic        st_rd,
  output logic        tx_out,
  output logic [31:0] out_word,
  output logic        busy,
  output logic        err
);

  localparam int         TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] MAX_N      = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    HDR,
    DRAIN
  } state_t;

  state_t        state;
  logic [7:0]    n_words;
  logic [7:0]    word_cnt;
  logic [TW-1:0] timer;
  logic          aborted;
  logic [1:0]    rst_pipe;
  logic          rst_hold;

  logic [7:0]    hdr_n;
  logic          is_sync;
  logic          hdr_ok;

  // Header decode of the incoming word; reserved bits [23:16] and [15:8] are ignored.
  assign hdr_n   = word_in[7:0];
  assign is_sync = (word_in[31:24] == SYNC);
  assign hdr_ok  = is_sync && (hdr_n != 8'd0) && (hdr_n <= MAX_N);

  // Strobes into self_test are decoded straight from state and counters so they
  // line up with the word currently on word_in / st_data_in.
  assign st_load  = (state == LOAD) && (word_cnt < n_words);
  assign st_start = (state == LOAD) && (word_cnt == n_words);
  assign st_rd    = (state == DRAIN) && !aborted;
  assign busy     = (state != IDLE);
  assign rst_hold = rst_pipe[1];

  // Reset release synchronizer: rst asserts everything at once, but the FSM is
  // kept cleared for two more word clocks so removal is aligned to div_8_clk.
  always_ff @(posedge div_8_clk or posedge rst) begin
    if (rst) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  // Packet sequencer with registered serializer outputs and sticky error flag.
  always_ff @(posedge div_8_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      n_words  <= 8'd0;
      word_cnt <= 8'd0;
      timer    <= '0;
      aborted  <= 1'b0;
      err      <= 1'b0;
      tx_out   <= 1'b0;
      out_word <= 32'h0;
    end else if (rst_hold) begin
      state    <= IDLE;
      n_words  <= 8'd0;
      word_cnt <= 8'd0;
      timer    <= '0;
      aborted  <= 1'b0;
      err      <= 1'b0;
      tx_out   <= 1'b0;
      out_word <= 32'h0;
    end else begin
      tx_out   <= 1'b0;
      out_word <= 32'h0;
      case (state)
        IDLE: begin
          if (!f_layer) begin
            tx_out   <= 1'b1;
            out_word <= word_in;
          end else if (is_sync) begin
            if (hdr_ok) begin
              n_words  <= hdr_n;
              word_cnt <= 8'd0;
              aborted  <= 1'b0;
              err      <= 1'b0;
              state    <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (word_cnt < n_words) begin
            word_cnt <= word_cnt + 8'd1;
          end else begin
            timer <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          if (sort_finish) begin
            state <= HDR;
          end else if (timer == TIMER_LAST) begin
            err     <= 1'b1;
            aborted <= 1'b1;
            state   <= HDR;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        HDR: begin
          tx_out   <= 1'b1;
          out_word <= {SYNC, 7'b0, err, 8'b0, n_words};
          word_cnt <= 8'd0;
          state    <= DRAIN;
        end

        DRAIN: begin
          tx_out   <= 1'b1;
          out_word <= aborted ? 32'h0 : st_data_in;
          if (word_cnt == n_words - 8'd1) begin
            state <= IDLE;
          end else begin
            word_cnt <= word_cnt + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_self_test_sequencer.sv
// Directed testbench for self_test_sequencer with a small self_test result model.

module tb_self_test_sequencer;

  localparam int TIMEOUT = 1024;

  logic        div_8_clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_layer = 1'b1;
  logic [31:0] word_in = 32'h0;
  logic        sort_finish = 1'b0;
  logic [31:0] st_data_in;
  logic        st_load, st_start, st_rd, tx_out, busy, err;
  logic [31:0] out_word;

  int checks = 0;
  int failures = 0;

  self_test_sequencer dut (
    .div_8_clk  (div_8_clk),
    .rst        (rst),
    .f_layer    (f_layer),
    .word_in    (word_in),
    .sort_finish(sort_finish),
    .st_data_in (st_data_in),
    .st_load    (st_load),
    .st_start   (st_start),
    .st_rd      (st_rd),
    .tx_out     (tx_out),
    .out_word   (out_word),
    .busy       (busy),
    .err        (err)
  );

  always #5 div_8_clk = ~div_8_clk;

  // self_test result model: presents C0DE_<ptr>, pointer advances after each st_rd cycle
  logic rd_pending = 1'b0;
  int   rd_ptr = 0;
  assign st_data_in = {16'hC0DE, rd_ptr[15:0]};

  always @(negedge div_8_clk) rd_pending <= st_rd && !rst;
  always @(posedge div_8_clk) if (rd_pending) rd_ptr <= rd_ptr + 1;

  // Monitor: counts strobes, records loaded and emitted words, measures RUN+HDR length
  int          load_total = 0;
  int          start_total = 0;
  int          rd_total = 0;
  logic [31:0] outq[$];
  logic [31:0] loadq[$];
  bit          gap_on = 1'b0;
  int          gap_cnt = 0;
  int          last_gap = -1;

  always @(negedge div_8_clk) begin
    if (!rst) begin
      if (st_load) begin
        load_total++;
        loadq.push_back(word_in);
      end
      if (st_start) begin
        start_total++;
        gap_on = 1'b1;
        gap_cnt = 0;
      end else if (gap_on) begin
        if (tx_out) begin
          last_gap = gap_cnt;
          gap_on = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
      if (st_rd) rd_total++;
      if (tx_out) outq.push_back(out_word);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    @(posedge div_8_clk);
    #1 word_in = w;
  endtask

  task automatic waitStart(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge div_8_clk);
      if (st_start) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("start_seen", 32'(seen), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge div_8_clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("idle_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge div_8_clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lb, sb, rb, ob, qb, pb;

    // ---------------- reset ----------------
    rst = 1'b1;
    repeat (3) @(posedge div_8_clk);
    @(negedge div_8_clk);
    checkOutput("rst_flags", 32'({st_load, st_start, st_rd, tx_out, busy, err}), 32'h0);
    checkOutput("rst_out_word", out_word, 32'h0);
    @(posedge div_8_clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge div_8_clk);

    // ---------------- test 1: normal 4-word packet ----------------
    lb = load_total; sb = start_total; rb = rd_total; ob = outq.size(); qb = loadq.size(); pb = rd_ptr;
    applyStimulus(32'h1234_5678);
    applyStimulus(32'hA500_0004);
    applyStimulus(32'h1111_0001);
    applyStimulus(32'h1111_0002);
    applyStimulus(32'h1111_0003);
    applyStimulus(32'h1111_0004);
    waitStart(10);
    repeat (10) @(posedge div_8_clk);
    #1 sort_finish = 1'b1;
    waitIdle(50);
    sort_finish = 1'b0;
    word_in = 32'h0;
    checkOutput("t1_load_cnt", 32'(load_total - lb), 32'd4);
    for (int k = 0; k < 4; k++)
      checkOutput("t1_load_word", loadq[qb + k], 32'h1111_0001 + 32'(k));
    checkOutput("t1_start_cnt", 32'(start_total - sb), 32'd1);
    checkOutput("t1_run_gap", 32'(last_gap), 32'd11);
    checkOutput("t1_rd_cnt", 32'(rd_total - rb), 32'd4);
    checkOutput("t1_out_cnt", 32'(outq.size() - ob), 32'd5);
    checkOutput("t1_hdr", outq[ob], 32'hA500_0004);
    for (int k = 0; k < 4; k++)
      checkOutput("t1_data", outq[ob + 1 + k], {16'hC0DE, 16'(pb + k)});
    checkOutput("t1_busy", 32'(busy), 32'd0);

    // ---------------- test 2: forward mode ----------------
    f_layer = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(32'(i));
      @(negedge div_8_clk);
      checkOutput("t2_fwd_word", out_word, 32'(i - 1));
      checkOutput("t2_fwd_tx", 32'(tx_out), 32'd1);
      checkOutput("t2_fwd_quiet", 32'({st_load, st_start, st_rd, busy}), 32'h0);
    end
    applyStimulus(32'h0);
    f_layer = 1'b1;
    applyStimulus(32'h0);
    @(negedge div_8_clk);
    checkOutput("t2_tx_off", 32'(tx_out), 32'd0);

    // ---------------- test 3: illegal headers then a 1-word packet ----------------
    lb = load_total; ob = outq.size(); qb = loadq.size();
    applyStimulus(32'hA500_0000);
    applyStimulus(32'h0);
    @(negedge div_8_clk);
    checkOutput("t3_err_n0", 32'({err, busy}), 32'b10);
    applyStimulus(32'hA500_0011);
    applyStimulus(32'h0);
    @(negedge div_8_clk);
    checkOutput("t3_err_n17", 32'({err, busy}), 32'b10);
    checkOutput("t3_no_load", 32'(load_total - lb), 32'd0);
    checkOutput("t3_no_out", 32'(outq.size() - ob), 32'd0);
    pb = rd_ptr;
    applyStimulus(32'hA500_0001);
    applyStimulus(32'hBEEF_0001);
    @(negedge div_8_clk);
    checkOutput("t3_err_clr", 32'({err, st_load, busy}), 32'b011);
    waitStart(5);
    sort_finish = 1'b1;
    waitIdle(20);
    sort_finish = 1'b0;
    checkOutput("t3_load_cnt", 32'(load_total - lb), 32'd1);
    checkOutput("t3_load_word", loadq[qb], 32'hBEEF_0001);
    checkOutput("t3_run_gap", 32'(last_gap), 32'd2);
    checkOutput("t3_hdr", outq[ob], 32'hA500_0001);
    checkOutput("t3_data", outq[ob + 1], {16'hC0DE, 16'(pb)});
    checkOutput("t3_err_end", 32'(err), 32'd0);

    // ---------------- test 4: sort timeout ----------------
    rb = rd_total; ob = outq.size();
    applyStimulus(32'hA500_0002);
    applyStimulus(32'h2222_0001);
    applyStimulus(32'h2222_0002);
    waitStart(5);
    waitIdle(TIMEOUT + 50);
    checkOutput("t4_run_gap", 32'(last_gap), 32'(TIMEOUT + 1));
    checkOutput("t4_err", 32'(err), 32'd1);
    checkOutput("t4_rd_cnt", 32'(rd_total - rb), 32'd0);
    checkOutput("t4_out_cnt", 32'(outq.size() - ob), 32'd3);
    checkOutput("t4_hdr", outq[ob], 32'hA501_0002);
    checkOutput("t4_zero0", outq[ob + 1], 32'h0);
    checkOutput("t4_zero1", outq[ob + 2], 32'h0);

    // ---------------- test 5: reset during LOAD ----------------
    lb = load_total; ob = outq.size();
    applyStimulus(32'hA500_0004);
    applyStimulus(32'h5555_0001);
    applyStimulus(32'h5555_0002);
    applyStimulus(32'h5555_0003);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_flags", 32'({st_load, st_start, st_rd, tx_out, busy, err}), 32'h0);
    checkOutput("t5_rst_word", out_word, 32'h0);
    repeat (2) @(posedge div_8_clk);
    #1 rst = 1'b0;
    applyStimulus(32'h5555_0004);
    for (int i = 0; i < 6; i++) applyStimulus(32'h0);
    @(negedge div_8_clk);
    checkOutput("t5_partial_load", 32'(load_total - lb), 32'd2);
    checkOutput("t5_no_out", 32'(outq.size() - ob), 32'd0);
    checkOutput("t5_idle", 32'(busy), 32'd0);
    lb = load_total; ob = outq.size(); pb = rd_ptr;
    applyStimulus(32'hA500_0002);
    applyStimulus(32'h6666_0001);
    applyStimulus(32'h6666_0002);
    waitStart(5);
    sort_finish = 1'b1;
    waitIdle(20);
    sort_finish = 1'b0;
    checkOutput("t5_load_cnt", 32'(load_total - lb), 32'd2);
    checkOutput("t5_hdr", outq[ob], 32'hA500_0002);
    checkOutput("t5_data0", outq[ob + 1], {16'hC0DE, 16'(pb)});
    checkOutput("t5_data1", outq[ob + 2], {16'hC0DE, 16'(pb + 1)});

    // ---------------- test 6: sync word in payload, f_layer flip in RUN ----------------
    lb = load_total; sb = start_total; ob = outq.size(); qb = loadq.size(); pb = rd_ptr;
    applyStimulus(32'hA500_0004);
    applyStimulus(32'h7777_0001);
    applyStimulus(32'hA500_0003);
    applyStimulus(32'h7777_0003);
    applyStimulus(32'h7777_0004);
    waitStart(5);
    @(posedge div_8_clk);
    #1 f_layer = 1'b0;
    @(negedge div_8_clk);
    checkOutput("t6_run_no_fwd", 32'({busy, tx_out}), 32'b10);
    repeat (2) @(posedge div_8_clk);
    #1 sort_finish = 1'b1;
    waitIdle(30);
    sort_finish = 1'b0;
    checkOutput("t6_load_cnt", 32'(load_total - lb), 32'd4);
    checkOutput("t6_load0", loadq[qb], 32'h7777_0001);
    checkOutput("t6_load_sync", loadq[qb + 1], 32'hA500_0003);
    checkOutput("t6_load2", loadq[qb + 2], 32'h7777_0003);
    checkOutput("t6_load3", loadq[qb + 3], 32'h7777_0004);
    checkOutput("t6_start_cnt", 32'(start_total - sb), 32'd1);
    checkOutput("t6_run_gap", 32'(last_gap), 32'd4);
    checkOutput("t6_hdr", outq[ob], 32'hA500_0004);
    for (int k = 0; k < 4; k++)
      checkOutput("t6_data", outq[ob + 1 + k], {16'hC0DE, 16'(pb + k)});
    applyStimulus(32'h5A5A_0001);
    applyStimulus(32'h5A5A_0002);
    @(negedge div_8_clk);
    checkOutput("t6_fwd_word", out_word, 32'h5A5A_0001);
    checkOutput("t6_fwd_flags", 32'({tx_out, busy}), 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
